fu_alu_acc_pipe: RTL and testbench

- Parametrised, pipelined successor of the 2-input CGRA ALU functional cell.
- Adds configurable data width and output pipeline depth, valid tracking, signed compare/min/max, and arithmetic shift.
- Adds an internal accumulator for MAC/ACC ops, so a PE can reduce without routing through a register cell.
- Sits in the PE as a FUNC_CELL; driven by the routing muxes, with config_sig from the config chain.

---
 rtl/fu_pkg.sv | 24 ++
 rtl/fu_alu_acc_pipe_if.sv | 15 +
 rtl/fu_alu_core.sv | 63 ++++++
 rtl/fu_alu_acc_pipe.sv | 70 +++++++
 tb/tb_fu_alu_acc_pipe.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fu_pkg.sv
// Opcode encoding shared by the ALU/accumulator functional cell, its core and its bus.
package fu_pkg;
  localparam int OPW = 5;

  typedef logic [OPW-1:0] opcode_t;

  localparam opcode_t OP_ADD  = 5'd0;
  localparam opcode_t OP_SUB  = 5'd1;
  localparam opcode_t OP_MUL  = 5'd2;
  localparam opcode_t OP_AND  = 5'd3;
  localparam opcode_t OP_OR   = 5'd4;
  localparam opcode_t OP_XOR  = 5'd5;
  localparam opcode_t OP_SHL  = 5'd6;
  localparam opcode_t OP_SHR  = 5'd7;
  localparam opcode_t OP_PA   = 5'd8;
  localparam opcode_t OP_PB   = 5'd9;
  localparam opcode_t OP_SRA  = 5'd10;
  localparam opcode_t OP_SLT  = 5'd11;
  localparam opcode_t OP_EQ   = 5'd12;
  localparam opcode_t OP_MIN  = 5'd13;
  localparam opcode_t OP_MAX  = 5'd14;
  localparam opcode_t OP_MAC  = 5'd15;
  localparam opcode_t OP_ACC  = 5'd16;
endpackage

// File: rtl/fu_alu_acc_pipe_if.sv
// Operand/result bus of the functional cell; master is the PE routing side.
interface fu_alu_acc_pipe_if #(parameter int size = 32);
  logic [fu_pkg::OPW-1:0] config_sig;
  logic [size-1:0]        in0;
  logic [size-1:0]        in1;
  logic                   in_valid;
  logic                   acc_clr;
  logic [size-1:0]        out0;
  logic                   out_valid;

  modport master (output config_sig, in0, in1, in_valid, acc_clr,
                  input  out0, out_valid);
  modport slave  (input  config_sig, in0, in1, in_valid, acc_clr,
                  output out0, out_valid);
endinterface

// File: rtl/fu_alu_core.sv
// Combinational op mux: result and next accumulator value for one operand pair.
module fu_alu_core
  import fu_pkg::*;
#(
  parameter int size = 32
) (
  input  logic [size-1:0] i_in0,
  input  logic [size-1:0] i_in1,
  input  opcode_t         i_opcode,
  input  logic [size-1:0] i_acc,
  output logic [size-1:0] o_result,
  output logic [size-1:0] o_acc_next
);
  localparam int SHW = $clog2(size);

  logic [SHW-1:0]  w_sh;
  logic [size-1:0] w_prod;
  logic [size-1:0] w_sra;
  logic [size-1:0] w_mac;
  logic [size-1:0] w_accum;
  logic            w_lt;
  logic            w_eq;

  assign w_sh    = i_in1[SHW-1:0];
  assign w_prod  = i_in0 * i_in1;
  assign w_lt    = $signed(i_in0) < $signed(i_in1);
  assign w_eq    = (i_in0 == i_in1);
  assign w_sra   = $unsigned($signed(i_in0) >>> w_sh);
  // i_acc arrives already cleared when acc_clr coincides with an accumulate op
  assign w_mac   = i_acc + w_prod;
  assign w_accum = i_acc + i_in0;

  always_comb begin
    o_result   = '0;
    o_acc_next = i_acc;
    case (i_opcode)
      OP_ADD: o_result = i_in0 + i_in1;
      OP_SUB: o_result = i_in0 - i_in1;
      OP_MUL: o_result = w_prod;
      OP_AND: o_result = i_in0 & i_in1;
      OP_OR:  o_result = i_in0 | i_in1;
      OP_XOR: o_result = i_in0 ^ i_in1;
      OP_SHL: o_result = i_in0 << w_sh;
      OP_SHR: o_result = i_in0 >> w_sh;
      OP_PA:  o_result = i_in0;
      OP_PB:  o_result = i_in1;
      OP_SRA: o_result = w_sra;
      OP_SLT: o_result = {{(size-1){1'b0}}, w_lt};
      OP_EQ:  o_result = {{(size-1){1'b0}}, w_eq};
      OP_MIN: o_result = w_lt ? i_in0 : i_in1;
      OP_MAX: o_result = w_lt ? i_in1 : i_in0;
      OP_MAC: begin
        o_result   = w_mac;
        o_acc_next = w_mac;
      end
      OP_ACC: begin
        o_result   = w_accum;
        o_acc_next = w_accum;
      end
      default: o_result = '0;
    endcase
  end
endmodule

// File: rtl/fu_alu_acc_pipe.sv
// Pipelined ALU functional cell with internal accumulator; latency 1+PIPE.
module fu_alu_acc_pipe
  import fu_pkg::*;
#(
  parameter int size = 32,
  parameter int PIPE = 0
) (
  input logic              clk,
  input logic              reset,
  fu_alu_acc_pipe_if.slave fu_if
);
  logic [size-1:0] r_acc;
  logic [size-1:0] w_acc_base;
  logic [size-1:0] w_result;
  logic [size-1:0] w_acc_next;
  logic            w_is_acc;

  assign w_acc_base = fu_if.acc_clr ? '0 : r_acc;
  assign w_is_acc   = (fu_if.config_sig == OP_MAC) || (fu_if.config_sig == OP_ACC);

  fu_alu_core #(.size(size)) u_core (
    .i_in0      (fu_if.in0),
    .i_in1      (fu_if.in1),
    .i_opcode   (fu_if.config_sig),
    .i_acc      (w_acc_base),
    .o_result   (w_result),
    .o_acc_next (w_acc_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
    end else if (fu_if.in_valid && w_is_acc) begin
      r_acc <= w_acc_next;
    end else if (fu_if.acc_clr) begin
      r_acc <= '0;
    end
  end

  // Stage 0 is the compute register; later stages only load on a valid so out0 holds between results
  for (genvar g = 0; g <= PIPE; g++) begin : g_stage
    logic [size-1:0] r_data;
    logic            r_vld;

    if (g == 0) begin : g_first
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_data <= '0;
          r_vld  <= 1'b0;
        end else begin
          r_vld <= fu_if.in_valid;
          if (fu_if.in_valid) r_data <= w_result;
        end
      end
    end else begin : g_next
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_data <= '0;
          r_vld  <= 1'b0;
        end else begin
          r_vld <= g_stage[g-1].r_vld;
          if (g_stage[g-1].r_vld) r_data <= g_stage[g-1].r_data;
        end
      end
    end
  end

  assign fu_if.out0      = g_stage[PIPE].r_data;
  assign fu_if.out_valid = g_stage[PIPE].r_vld;
endmodule

// File: tb/tb_fu_alu_acc_pipe.sv
// Bench for fu_alu_acc_pipe: four parameterisations driven by directed and random stimulus.
module tb_fu_alu_acc_pipe;
  localparam int ND = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Drive/observe arrays indexed by DUT: 0=(32,0) 1=(8,2) 2=(8,0) 3=(16,1)
  logic [4:0]  d_op  [ND];
  logic [63:0] d_a   [ND];
  logic [63:0] d_b   [ND];
  logic        d_v   [ND];
  logic        d_clr [ND];
  logic [63:0] o_d   [ND];
  logic        o_v   [ND];

  fu_alu_acc_pipe_if #(.size(32)) if0 ();
  fu_alu_acc_pipe_if #(.size(8))  if1 ();
  fu_alu_acc_pipe_if #(.size(8))  if2 ();
  fu_alu_acc_pipe_if #(.size(16)) if3 ();

  fu_alu_acc_pipe #(.size(32), .PIPE(0)) dut0 (.clk(clk), .reset(reset), .fu_if(if0.slave));
  fu_alu_acc_pipe #(.size(8),  .PIPE(2)) dut1 (.clk(clk), .reset(reset), .fu_if(if1.slave));
  fu_alu_acc_pipe #(.size(8),  .PIPE(0)) dut2 (.clk(clk), .reset(reset), .fu_if(if2.slave));
  fu_alu_acc_pipe #(.size(16), .PIPE(1)) dut3 (.clk(clk), .reset(reset), .fu_if(if3.slave));

  assign if0.config_sig = d_op[0]; assign if0.in0 = d_a[0][31:0]; assign if0.in1 = d_b[0][31:0];
  assign if0.in_valid = d_v[0]; assign if0.acc_clr = d_clr[0];
  assign if1.config_sig = d_op[1]; assign if1.in0 = d_a[1][7:0]; assign if1.in1 = d_b[1][7:0];
  assign if1.in_valid = d_v[1]; assign if1.acc_clr = d_clr[1];
  assign if2.config_sig = d_op[2]; assign if2.in0 = d_a[2][7:0]; assign if2.in1 = d_b[2][7:0];
  assign if2.in_valid = d_v[2]; assign if2.acc_clr = d_clr[2];
  assign if3.config_sig = d_op[3]; assign if3.in0 = d_a[3][15:0]; assign if3.in1 = d_b[3][15:0];
  assign if3.in_valid = d_v[3]; assign if3.acc_clr = d_clr[3];

  assign o_d[0] = 64'(if0.out0); assign o_v[0] = if0.out_valid;
  assign o_d[1] = 64'(if1.out0); assign o_v[1] = if1.out_valid;
  assign o_d[2] = 64'(if2.out0); assign o_v[2] = if2.out_valid;
  assign o_d[3] = 64'(if3.out0); assign o_v[3] = if3.out_valid;

  function automatic int width_of(int d);
    case (d)
      0: return 32;
      3: return 16;
      default: return 8;
    endcase
  endfunction

  function automatic int pipe_of(int d);
    case (d)
      1: return 2;
      3: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [63:0] mask_w(int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic longint sx(logic [63:0] x, int w);
    return longint'(x << (64 - w)) >>> (64 - w);
  endfunction

  // Reference behaviour from the opcode table; acc passed in is already cleared if acc_clr applies
  function automatic void ref_op(input int w, input logic [4:0] op, input logic [63:0] a,
                                 input logic [63:0] b, input logic [63:0] acc,
                                 output logic [63:0] res, output logic [63:0] acc_o);
    logic [63:0] m;
    int sh;
    m = mask_w(w);
    sh = int'(b & mask_w($clog2(w)));
    acc_o = acc;
    case (op)
      5'd0:  res = a + b;
      5'd1:  res = a - b;
      5'd2:  res = a * b;
      5'd3:  res = a & b;
      5'd4:  res = a | b;
      5'd5:  res = a ^ b;
      5'd6:  res = a << sh;
      5'd7:  res = a >> sh;
      5'd8:  res = a;
      5'd9:  res = b;
      5'd10: res = 64'(sx(a, w) >>> sh);
      5'd11: res = (sx(a, w) < sx(b, w)) ? 64'd1 : 64'd0;
      5'd12: res = (a == b) ? 64'd1 : 64'd0;
      5'd13: res = (sx(a, w) < sx(b, w)) ? a : b;
      5'd14: res = (sx(a, w) < sx(b, w)) ? b : a;
      5'd15: begin res = (acc + a * b) & m; acc_o = res; end
      5'd16: begin res = (acc + a) & m; acc_o = res; end
      default: res = 64'd0;
    endcase
    res = res & m;
  endfunction

  task automatic idle_all();
    for (int d = 0; d < ND; d++) begin
      d_op[d] = 5'd0; d_a[d] = 64'd0; d_b[d] = 64'd0; d_v[d] = 1'b0; d_clr[d] = 1'b0;
    end
  endtask

  task automatic drive(int d, logic [4:0] op, logic [63:0] a, logic [63:0] b, logic v, logic clr);
    d_op[d] = op; d_a[d] = a; d_b[d] = b; d_v[d] = v; d_clr[d] = clr;
  endtask

  task automatic test_reset();
    #1;
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (o_v[d] !== 1'b0 || o_d[d] !== 64'd0) begin
        errors++;
        $display("FAIL reset_hold dut%0d: got v=%0b d=%0h, expected v=0 d=0", d, o_v[d], o_d[d]);
      end
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (o_v[d] !== 1'b0 || o_d[d] !== 64'd0) begin
        errors++;
        $display("FAIL reset_release dut%0d: got v=%0b d=%0h, expected v=0 d=0", d, o_v[d], o_d[d]);
      end
    end
  endtask

  task automatic test_add();
    drive(0, 5'd0, 64'd5, 64'd7, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (o_v[0] !== 1'b1 || o_d[0] !== 64'd12) begin
      errors++;
      $display("FAIL add_lat1: got v=%0b d=%0h, expected v=1 d=c", o_v[0], o_d[0]);
    end
    drive(0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (o_v[0] !== 1'b0 || o_d[0] !== 64'd12) begin
      errors++;
      $display("FAIL add_single_pulse: got v=%0b d=%0h, expected v=0 d=c", o_v[0], o_d[0]);
    end
  endtask

  task automatic test_idle_hold();
    for (int i = 0; i < 10; i++) begin
      drive(0, 5'd0, 64'($urandom), 64'($urandom), 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (o_v[0] !== 1'b0 || o_d[0] !== 64'd12) begin
        errors++;
        $display("FAIL idle_hold cyc%0d: got v=%0b d=%0h, expected v=0 d=c", i, o_v[0], o_d[0]);
      end
    end
    drive(0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic        ev [6];
    logic [63:0] ed [6];
    ev = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    ed = '{64'h0, 64'h0, 64'hFE, 64'h90, 64'h90, 64'h90};
    drive(1, 5'd1, 64'd3, 64'd5, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (o_v[1] !== ev[i] || (ev[i] && o_d[1] !== ed[i]) || (i >= 4 && o_d[1] !== ed[i])) begin
        errors++;
        $display("FAIL b2b_pipe2 step%0d: got v=%0b d=%0h, expected v=%0b d=%0h", i, o_v[1], o_d[1], ev[i], ed[i]);
      end
      if (i == 0) drive(1, 5'd2, 64'd20, 64'd20, 1'b1, 1'b0);
      else drive(1, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_ops();
    logic [4:0] top [13];
    logic [7:0] ta  [13];
    logic [7:0] tb  [13];
    logic [7:0] tx  [13];
    top = '{5'd10, 5'd7, 5'd11, 5'd13, 5'd6, 5'd0, 5'd12, 5'd14, 5'd20, 5'd1, 5'd5, 5'd9, 5'd11};
    ta  = '{8'h80, 8'h80, 8'hFF, 8'hFF, 8'h01, 8'hFF, 8'h05, 8'hFF, 8'h12, 8'h00, 8'hF0, 8'h11, 8'h01};
    tb  = '{8'h03, 8'h03, 8'h01, 8'h01, 8'h09, 8'h02, 8'h05, 8'h01, 8'h34, 8'h01, 8'h3C, 8'h22, 8'hFF};
    tx  = '{8'hF0, 8'h10, 8'h01, 8'hFF, 8'h02, 8'h01, 8'h01, 8'h01, 8'h00, 8'hFF, 8'hCC, 8'h22, 8'h00};
    for (int i = 0; i < 13; i++) begin
      drive(2, top[i], 64'(ta[i]), 64'(tb[i]), 1'b1, 1'b0);
      @(negedge clk);
      checks++;
      if (o_v[2] !== 1'b1 || o_d[2] !== 64'(tx[i])) begin
        errors++;
        $display("FAIL op%0d_%0h_%0h: got v=%0b d=%0h, expected v=1 d=%0h", top[i], ta[i], tb[i], o_v[2], o_d[2], tx[i]);
      end
    end
    drive(2, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0);
  endtask

  task automatic test_mac();
    logic [4:0]  mop [7];
    logic [63:0] ma  [7];
    logic [63:0] mb  [7];
    logic        mv  [7];
    logic        mc  [7];
    logic [63:0] mx  [7];
    mop = '{5'd15, 5'd15, 5'd15, 5'd15, 5'd0, 5'd16, 5'd0};
    ma  = '{64'd2, 64'd4, 64'd1, 64'd7, 64'd0, 64'd1, 64'd0};
    mb  = '{64'd3, 64'd5, 64'd1, 64'd2, 64'd0, 64'd0, 64'd0};
    mv  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    mc  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    mx  = '{64'd6, 64'd26, 64'd27, 64'd14, 64'd14, 64'd1, 64'd1};
    for (int i = 0; i < 7; i++) begin
      drive(3, mop[i], ma[i], mb[i], mv[i], mc[i]);
      @(negedge clk);
      if (i >= 1) begin
        checks++;
        if (o_v[3] !== mv[i-1] || o_d[3] !== mx[i-1]) begin
          errors++;
          $display("FAIL mac_seq item%0d: got v=%0b d=%0h, expected v=%0b d=%0h", i - 1, o_v[3], o_d[3], mv[i-1], mx[i-1]);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    drive(3, 5'd15, 64'd3, 64'd3, 1'b1, 1'b0);
    @(negedge clk);
    drive(3, 5'd15, 64'd2, 64'd2, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (o_v[3] !== 1'b1 || o_d[3] !== 64'd10) begin
      errors++;
      $display("FAIL pre_reset_result: got v=%0b d=%0h, expected v=1 d=a", o_v[3], o_d[3]);
    end
    reset = 1'b1;
    drive(3, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (o_v[3] !== 1'b0 || o_d[3] !== 64'd0) begin
      errors++;
      $display("FAIL async_reset_clear: got v=%0b d=%0h, expected v=0 d=0", o_v[3], o_d[3]);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (o_v[3] !== 1'b0 || o_d[3] !== 64'd0) begin
        errors++;
        $display("FAIL flushed_after_reset cyc%0d: got v=%0b d=%0h, expected v=0 d=0", i, o_v[3], o_d[3]);
      end
    end
    drive(3, 5'd15, 64'd1, 64'd1, 1'b1, 1'b0);
    @(negedge clk);
    drive(3, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0);
    checks++;
    if (o_v[3] !== 1'b0) begin
      errors++;
      $display("FAIL mac_after_reset_early: got v=%0b, expected v=0", o_v[3]);
    end
    @(negedge clk);
    checks++;
    if (o_v[3] !== 1'b1 || o_d[3] !== 64'd1) begin
      errors++;
      $display("FAIL mac_after_reset: got v=%0b d=%0h, expected v=1 d=1", o_v[3], o_d[3]);
    end
  endtask

  // Scoreboard keyed by the cycle count at which each result must appear
  logic        sb_v    [ND][8];
  logic [63:0] sb_d    [ND][8];
  logic [63:0] m_acc   [ND];
  logic [63:0] m_last  [ND];

  task automatic test_random();
    logic [4:0]  op;
    logic [63:0] a, b, m, res, accn, acc_in;
    logic        v, clr;
    int          slot, w;
    reset = 1'b1;
    idle_all();
    @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < ND; d++) begin
      m_acc[d] = 64'd0; m_last[d] = 64'd0;
      for (int s = 0; s < 8; s++) begin sb_v[d][s] = 1'b0; sb_d[d][s] = 64'd0; end
    end
    for (int it = 0; it < 400; it++) begin
      for (int d = 0; d < ND; d++) begin
        slot = cyc & 7;
        checks++;
        if (sb_v[d][slot]) begin
          if (o_v[d] !== 1'b1 || o_d[d] !== sb_d[d][slot]) begin
            errors++;
            $display("FAIL rand dut%0d it%0d: got v=%0b d=%0h, expected v=1 d=%0h", d, it, o_v[d], o_d[d], sb_d[d][slot]);
          end
          m_last[d] = sb_d[d][slot];
          sb_v[d][slot] = 1'b0;
        end else if (o_v[d] !== 1'b0 || o_d[d] !== m_last[d]) begin
          errors++;
          $display("FAIL rand_idle dut%0d it%0d: got v=%0b d=%0h, expected v=0 d=%0h", d, it, o_v[d], o_d[d], m_last[d]);
        end
        w = width_of(d);
        m = mask_w(w);
        op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16));
        a = {32'($urandom), 32'($urandom)} & m;
        b = {32'($urandom), 32'($urandom)} & m;
        v = (it < 395) && ($urandom_range(0, 3) != 0);
        clr = ($urandom_range(0, 7) == 0);
        acc_in = clr ? 64'd0 : m_acc[d];
        if (v) begin
          ref_op(w, op, a, b, acc_in, res, accn);
          m_acc[d] = accn;
          slot = (cyc + 1 + pipe_of(d)) & 7;
          sb_v[d][slot] = 1'b1;
          sb_d[d][slot] = res;
        end else if (clr) begin
          m_acc[d] = 64'd0;
        end
        drive(d, op, a, b, v, clr);
      end
      @(negedge clk);
    end
    idle_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_all();
    test_reset();
    test_add();
    test_idle_hold();
    test_back_to_back();
    test_ops();
    test_mac();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
